// File: rtl/lcd_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_display_ctrl                                                         |
// | Runs the init sequence for a 16x2 HD44780 LCD on an 8-bit bus, then      |
// | copies the 32-character message ROM to the display on every mode change. |
// | Optional macro: LCD_AUTO_REFRESH_EN adds a periodic forced rewrite.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_display_ctrl #(
  parameter int EN_PULSE       = 12,
  parameter int CMD_WAIT       = 2500,
  parameter int CLR_WAIT       = 100000,
  parameter int PWRUP_WAIT     = 1000000,
  parameter int REFRESH_PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic [1:0] msg_sel,
  output logic [4:0] raddr,
  input  logic [7:0] rom_data,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5,
    S_IDLE  = 3'd6
  } state_t;

  localparam logic [31:0] c_pwrup_last = 32'(PWRUP_WAIT - 1);
  localparam logic [31:0] c_pulse_last = 32'(EN_PULSE - 1);
  localparam logic [31:0] c_cmd_last   = 32'(CMD_WAIT - 1);
  localparam logic [31:0] c_clr_last   = 32'(CLR_WAIT - 1);

  // Step map: 0-3 init commands, 4 = line-1 address, 5-20 line-1 chars,
  // 21 = line-2 address, 22-37 line-2 chars. Later passes start at step 4.
  localparam logic [5:0] c_step_clear = 6'd2;
  localparam logic [5:0] c_step_pass  = 6'd4;
  localparam logic [5:0] c_step_last  = 6'd37;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [5:0]  r_step;
  logic [1:0]  r_mode_meta;
  logic [1:0]  r_mode_sync;
  logic        r_pending;

  logic [5:0]  w_next_step;
  logic        w_cur_data;
  logic        w_next_data;
  logic        w_refresh_tick;

  function automatic logic is_data_step(input logic [5:0] s);
    return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [5:0] s);
    case (s)
      6'd0:    return 8'h38;
      6'd1:    return 8'h0C;
      6'd2:    return 8'h01;
      6'd3:    return 8'h06;
      6'd4:    return 8'h80;
      default: return 8'hC0;
    endcase
  endfunction

  assign w_next_step = r_step + 6'd1;
  assign w_cur_data  = is_data_step(r_step);
  assign w_next_data = is_data_step(w_next_step);
  assign LCD_RW      = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic [31:0] c_refresh_last = 32'(REFRESH_PERIOD - 1);
  logic [31:0] r_refresh_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
    end else if ((r_state == S_DONE) || (r_refresh_cnt == c_refresh_last)) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 32'd1;
    end
  end

  assign w_refresh_tick = (r_refresh_cnt == c_refresh_last);
`else
  // Without auto-refresh the period has no meaning; this term is never true.
  assign w_refresh_tick = (REFRESH_PERIOD < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_meta <= 2'd0;
      r_mode_sync <= 2'd0;
    end else begin
      r_mode_meta <= mode;
      r_mode_sync <= r_mode_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_PWRUP;
      r_timer   <= c_pwrup_last;
      r_step    <= 6'd0;
      r_pending <= 1'b0;
      msg_sel   <= 2'd0;
      raddr     <= 5'd0;
      LCD_DATA  <= 8'h00;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_ON    <= 1'b0;
      LCD_BLON  <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      LCD_ON   <= 1'b1;
      LCD_BLON <= 1'b1;
      done     <= 1'b0;

      if (w_refresh_tick || ((r_state != S_IDLE) && (r_mode_sync != msg_sel))) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_PWRUP: begin
          if (r_timer == 32'd0) begin
            r_state  <= S_SETUP;
            r_step   <= 6'd0;
            LCD_DATA <= cmd_byte(6'd0);
            LCD_RS   <= 1'b0;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        S_FETCH: begin
          LCD_DATA <= rom_data;
          LCD_RS   <= 1'b1;
          r_state  <= S_SETUP;
        end

        S_SETUP: begin
          LCD_EN  <= 1'b1;
          r_timer <= c_pulse_last;
          r_state <= S_PULSE;
        end

        S_PULSE: begin
          if (r_timer == 32'd0) begin
            LCD_EN  <= 1'b0;
            r_timer <= (r_step == c_step_clear) ? c_clr_last : c_cmd_last;
            r_state <= S_HOLD;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        S_HOLD: begin
          if (r_timer != 32'd0) begin
            r_timer <= r_timer - 32'd1;
          end else begin
            // raddr wraps 31 -> 0 on the last character of the pass.
            if (w_cur_data) begin
              raddr <= raddr + 5'd1;
            end
            if (r_step == c_step_last) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_step <= w_next_step;
              if (w_next_step == c_step_pass) begin
                msg_sel   <= r_mode_sync;
                r_pending <= 1'b0;
              end
              if (w_next_data) begin
                r_state <= S_FETCH;
              end else begin
                r_state  <= S_SETUP;
                LCD_DATA <= cmd_byte(w_next_step);
                LCD_RS   <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        S_IDLE: begin
          if ((r_mode_sync != msg_sel) || r_pending) begin
            busy      <= 1'b1;
            msg_sel   <= r_mode_sync;
            r_pending <= 1'b0;
            r_step    <= c_step_pass;
            LCD_DATA  <= cmd_byte(c_step_pass);
            LCD_RS    <= 1'b0;
            r_state   <= S_SETUP;
          end
        end

        default: begin
          r_state <= S_PWRUP;
          r_timer <= c_pwrup_last;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_display_ctrl                                                      |
// | Self-checking bench: bus log compared with a pass-level display model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_display_ctrl;

  localparam int EN_PULSE = 2;
  localparam int CMD_WAIT = 4;
  localparam int CLR_WAIT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] msg_sel;
  logic [4:0] raddr;
  logic [7:0] rom_data;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, busy, done;

  lcd_display_ctrl #(
    .EN_PULSE(EN_PULSE), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT),
    .PWRUP_WAIT(20), .REFRESH_PERIOD(500)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .msg_sel(msg_sel), .raddr(raddr),
    .rom_data(rom_data), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Message text: line 1 is common, line 2 names the mode; padded with spaces.
  function automatic logic [7:0] msg_char(input int sel, input int idx);
    string s;
    if (idx < 16) s = "Mode:";
    else case (sel)
      0:       s = "Easy";
      1:       s = "Normal";
      2:       s = "Hard";
      default: s = "EXTREME";
    endcase
    if ((idx % 16) < s.len()) return s[idx % 16];
    return 8'h20;
  endfunction

  logic [7:0] rom_mem [0:127];
  initial for (int i = 0; i < 128; i++) rom_mem[i] = msg_char(i / 32, i % 32);
  assign rom_data = rom_mem[{msg_sel, raddr}];

  // Bus monitor: logs every transfer and tallies timing violations.
  logic [8:0] logq[$];
  logic [8:0] cur = 9'h0;
  int done_cnt = 0, en_viol = 0, gap_viol = 0, clear_gaps = 0;
  int high_cnt = 0, gap = 0;
  bit prev_en = 0, have_prev = 0, after_clear = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 0; have_prev = 0; high_cnt = 0; gap = 0; after_clear = 0;
    end else begin
      if (done) done_cnt++;
      if (LCD_RW) en_viol++;
      if (LCD_EN) begin
        if (!prev_en) begin
          cur = {LCD_RS, LCD_DATA};
          logq.push_back(cur);
          if (have_prev) begin
            if (after_clear) begin
              clear_gaps++;
              if (gap < CLR_WAIT + 1) gap_viol++;
            end else if (gap < CMD_WAIT + 1) gap_viol++;
          end
          high_cnt = 0;
        end
        high_cnt++;
        if ({LCD_RS, LCD_DATA} != cur) en_viol++;
      end else begin
        if (prev_en) begin
          if (high_cnt != EN_PULSE) en_viol++;
          have_prev = 1;
          after_clear = (cur == 9'h001);
          gap = 0;
        end
        gap++;
      end
      prev_en = LCD_EN;
    end
  end

  int checks = 0, errors = 0;
  logic [8:0] expq[$];

  typedef struct {
    logic [1:0] mode;
    logic [1:0] exp_sel;
    int         exp_xfers;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference pass: optional init commands, then both lines with address commands.
  task automatic add_pass(input bit first, input int sel);
    if (first) begin
      expq.push_back(9'h038); expq.push_back(9'h00C);
      expq.push_back(9'h001); expq.push_back(9'h006);
    end
    expq.push_back(9'h080);
    for (int i = 0; i < 16; i++) expq.push_back({1'b1, msg_char(sel, i)});
    expq.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) expq.push_back({1'b1, msg_char(sel, i)});
  endtask

  task automatic compare_log(input int base, input string name);
    int bad = -1;
    chk(logq.size() - base == expq.size(), {name, " length"}, logq.size() - base, expq.size());
    for (int i = 0; i < expq.size() && base + i < logq.size(); i++)
      if (bad < 0 && logq[base + i] != expq[i]) bad = i;
    chk(bad < 0, {name, " content"}, (bad < 0) ? 0 : int'(logq[base + bad]),
        (bad < 0) ? 0 : int'(expq[bad]));
  endtask

  task automatic wait_done_cnt(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    chk(done_cnt >= target, {name, " done wait"}, done_cnt, target);
  endtask

  initial begin
    int base, d0, n;
    bit sel_ok, en_quiet;
    logic [1:0] m1, latest, v;
    int k, nchg;

    tbl[0] = '{mode: 2'd3, exp_sel: 2'd3, exp_xfers: 34};
    tbl[1] = '{mode: 2'd1, exp_sel: 2'd1, exp_xfers: 34};
    tbl[2] = '{mode: 2'd2, exp_sel: 2'd2, exp_xfers: 34};
    tbl[3] = '{mode: 2'd0, exp_sel: 2'd0, exp_xfers: 34};

    // Reset state and power-up
    repeat (3) tick();
    chk({LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, raddr, msg_sel, busy, done} == 21'h2,
        "reset outputs",
        int'({LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, raddr, msg_sel, busy, done}), 2);
    base = logq.size();
    rst = 1'b0;
    tick();
    chk(LCD_ON && LCD_BLON, "power on after release", int'({LCD_ON, LCD_BLON}), 3);
    en_quiet = !LCD_EN;
    for (int i = 1; i < 20; i++) begin tick(); if (LCD_EN) en_quiet = 0; end
    chk(en_quiet, "no EN during power-up wait", int'(en_quiet), 1);
    wait_done_cnt(1, 1000, "first pass");
    repeat (6) tick();
    chk(done_cnt == 1, "first pass done count", done_cnt, 1);
    chk(!busy && msg_sel == 2'd0 && raddr == 5'd0, "first pass idle state",
        int'({busy, msg_sel, raddr}), 0);
    expq.delete(); add_pass(1, 0);
    compare_log(base, "first pass log");
    chk(clear_gaps == 1, "clear hold observed", clear_gaps, 1);

    // Table: single mode change from IDLE
    for (int t = 0; t < 4; t++) begin
      base = logq.size(); d0 = done_cnt;
      mode = tbl[t].mode;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      chk(busy && n <= 3, "busy latency", n, 3);
      wait_done_cnt(d0 + 1, 800, "table pass");
      repeat (6) tick();
      chk(done_cnt == d0 + 1 && !busy, "table single pass", done_cnt - d0, 1);
      chk(msg_sel == tbl[t].exp_sel, "table msg_sel", msg_sel, tbl[t].exp_sel);
      chk(logq.size() - base == tbl[t].exp_xfers, "table transfer count",
          logq.size() - base, tbl[t].exp_xfers);
      expq.delete(); add_pass(0, tbl[t].exp_sel);
      compare_log(base, "table pass log");
    end

    // Mode changes mid-pass: old selection holds, one extra pass with latest value
    for (int it = 0; it < 5; it++) begin
      m1 = (it == 0) ? 2'd1 : mode + 2'($urandom_range(1, 3));
      k = (it == 0) ? 8 : $urandom_range(1, 28);
      nchg = (it == 0) ? 1 : $urandom_range(1, 3);
      base = logq.size(); d0 = done_cnt;
      mode = m1;
      n = 0;
      while (!(busy && raddr == 5'(k)) && n < 800) begin tick(); n++; end
      chk(busy && raddr == 5'(k), "reach character", raddr, k);
      latest = m1;
      sel_ok = 1;
      for (int c = 0; c < nchg; c++) begin
        v = (it == 0) ? 2'd2 : 2'($urandom_range(0, 3));
        if (v == mode) v = mode + 2'd1;
        mode = v; latest = v;
        repeat (3) begin tick(); if (msg_sel != m1) sel_ok = 0; end
      end
      n = 0;
      while (done_cnt < d0 + 1 && n < 800) begin
        tick(); n++;
        if (msg_sel != m1) sel_ok = 0;
      end
      chk(sel_ok, "msg_sel stable in pass", msg_sel, m1);
      wait_done_cnt(d0 + 2, 800, "extra pass");
      repeat (6) tick();
      chk(done_cnt == d0 + 2 && !busy, "exactly two passes", done_cnt - d0, 2);
      chk(msg_sel == latest, "latest selection", msg_sel, latest);
      expq.delete(); add_pass(0, m1); add_pass(0, latest);
      compare_log(base, "two-pass log");
    end

    // Reset asserted while EN is high mid-pass
    mode = mode + 2'd1;
    n = 0;
    while (!(LCD_EN && raddr >= 5'd5) && n < 800) begin tick(); n++; end
    chk(LCD_EN == 1'b1, "EN high before reset", LCD_EN, 1);
    rst = 1'b1;
    #1;
    chk(!LCD_EN && busy && !LCD_ON, "async reset", int'({LCD_EN, busy, LCD_ON}), 2);
    repeat (3) tick();
    rst = 1'b0;
    base = logq.size(); d0 = done_cnt;
    wait_done_cnt(d0 + 1, 1000, "post-reset pass");
    repeat (6) tick();
    chk(done_cnt == d0 + 1 && !busy, "post-reset single pass", done_cnt - d0, 1);
    expq.delete(); add_pass(1, mode);
    compare_log(base, "post-reset init log");
    chk(clear_gaps == 2, "clear hold after reset", clear_gaps, 2);
    chk(gap_viol == 0, "inter-transfer gaps", gap_viol, 0);
    chk(en_viol == 0, "EN pulse width and bus stability", en_viol, 0);

    // Long idle stretch
    base = logq.size(); d0 = done_cnt;
    repeat (1200) tick();
`ifdef LCD_AUTO_REFRESH_EN
    chk(done_cnt - d0 >= 1, "auto refresh passes", done_cnt - d0, 1);
    expq.delete();
    for (int p = 0; p < done_cnt - d0; p++) add_pass(0, mode);
    compare_log(base, "auto refresh log");
`else
    chk(logq.size() == base, "idle EN activity", logq.size() - base, 0);
    chk(done_cnt == d0, "idle done pulses", done_cnt - d0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
